lfsr_bank: RTL and testbench

LFSR_BANK -- requirements
Module: lfsr_bank

---
 rtl/lfsr_bank.sv | 121 ++++++++++++
 tb/tb_lfsr_bank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_bank.sv
// Bank of independent Fibonacci LFSR channels with per-channel reseeding,
// a sticky "returned to seed" flag and zero-state protection.
module lfsr_bank #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB800,
    parameter int               CHANNELS     = 4,
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001,
    localparam int              LCW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load_valid,
    input  logic [LCW-1:0]            load_chan,
    input  logic [WIDTH-1:0]          load_seed,
    output logic                      load_ready,
    output logic [CHANNELS*WIDTH-1:0] state_out,
    output logic [CHANNELS-1:0]       wrapped,
    output logic                      zero_fix
);

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        for (int k = 0; k < STEPS; k++) begin
            r = shift_once(r);
        end
        return r;
    endfunction

    // Reset seeds are staggered per channel so channels do not start in lockstep.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
        int m;
        m = n % WIDTH;
        if (m == 0) begin
            return v;
        end
        return (v << m) | (v >> (WIDTH - m));
    endfunction

    logic [WIDTH-1:0]    state_q [CHANNELS];
    logic [WIDTH-1:0]    state_d [CHANNELS];
    logic [WIDTH-1:0]    seed_q  [CHANNELS];
    logic [WIDTH-1:0]    seed_d  [CHANNELS];
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] wrapped_q;
    logic [CHANNELS-1:0] wrapped_d;
    logic                zero_fix_q;
    logic                zero_fix_d;
    logic                load_ready_q;
    logic                load_ready_d;
    logic                load_accept;
    logic [WIDTH-1:0]    seed_eff;

    always_comb begin
        load_accept  = load_valid && load_ready_q;
        seed_eff     = (load_seed == '0) ? DEFAULT_SEED : load_seed;
        zero_fix_d   = load_accept && (load_seed == '0);
        load_ready_d = !load_accept;
        wrapped_d    = wrapped_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            seed_d[i]  = seed_q[i];
            cnt_d[i]   = cnt_q[i];
            // A load of this channel takes priority over both zero recovery and advance.
            if (load_accept && (32'(load_chan) == i)) begin
                state_d[i]   = seed_eff;
                seed_d[i]    = seed_eff;
                cnt_d[i]     = '0;
                wrapped_d[i] = 1'b0;
            end else begin
                if (state_q[i] == '0) begin
                    state_d[i] = DEFAULT_SEED;
                    zero_fix_d = 1'b1;
                end else if (en) begin
                    state_d[i] = advance(state_q[i]);
                    cnt_d[i]   = cnt_q[i] + WIDTH'(STEPS);
                end
                wrapped_d[i] = wrapped_q[i] ||
                               ((state_d[i] == seed_d[i]) && (cnt_d[i] != '0));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= rotl(DEFAULT_SEED, i);
                seed_q[i]  <= rotl(DEFAULT_SEED, i);
                cnt_q[i]   <= '0;
            end
            wrapped_q    <= '0;
            zero_fix_q   <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                seed_q[i]  <= seed_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            wrapped_q    <= wrapped_d;
            zero_fix_q   <= zero_fix_d;
            load_ready_q <= load_ready_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign state_out[g*WIDTH +: WIDTH] = state_q[g];
    end

    assign wrapped    = wrapped_q;
    assign zero_fix   = zero_fix_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// Directed self-checking bench for lfsr_bank: default bank, a 4-bit
// maximal-length bank for the wrap flag, and a STEPS=4 bank.
module tb_lfsr_bank;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Default-parameter bank
    logic        en0, lv0, lr0, zf0;
    logic [1:0]  lc0;
    logic [15:0] ls0;
    logic [63:0] so0;
    logic [3:0]  wr0;

    // WIDTH=4, TAPS=4'hC, single channel
    logic        en1, lv1, lr1, zf1;
    logic [0:0]  lc1;
    logic [3:0]  ls1;
    logic [3:0]  so1;
    logic [0:0]  wr1;

    // STEPS=4 bank
    logic        en2, lv2, lr2, zf2;
    logic [1:0]  lc2;
    logic [15:0] ls2;
    logic [63:0] so2;
    logic [3:0]  wr2;

    lfsr_bank dut0 (
        .clk(clk), .rst(rst), .en(en0), .load_valid(lv0), .load_chan(lc0),
        .load_seed(ls0), .load_ready(lr0), .state_out(so0), .wrapped(wr0),
        .zero_fix(zf0)
    );

    lfsr_bank #(.WIDTH(4), .TAPS(4'hC), .CHANNELS(1), .STEPS(1), .DEFAULT_SEED(4'h1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .load_valid(lv1), .load_chan(lc1),
        .load_seed(ls1), .load_ready(lr1), .state_out(so1), .wrapped(wr1),
        .zero_fix(zf1)
    );

    lfsr_bank #(.STEPS(4)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .load_valid(lv2), .load_chan(lc2),
        .load_seed(ls2), .load_ready(lr2), .state_out(so2), .wrapped(wr2),
        .zero_fix(zf2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the default bank for one cycle and samples just after the edge.
    task automatic applyStimulus(input logic en, input logic lv, input logic [1:0] lc,
                                 input logic [15:0] ls);
        en0 = en;
        lv0 = lv;
        lc0 = lc;
        ls0 = ls;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        en0 = 0; lv0 = 0; lc0 = '0; ls0 = '0;
        en1 = 0; lv1 = 0; lc1 = '0; ls1 = '0;
        en2 = 0; lv2 = 0; lc2 = '0; ls2 = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("rst_state0", 64'(so0), 64'h0008_0004_0002_0001);
        checkOutput("rst_ready0", 64'(lr0), 64'h1);
        checkOutput("rst_wrap0",  64'(wr0), 64'h0);
        checkOutput("rst_zfix0",  64'(zf0), 64'h0);
        checkOutput("rst_state1", 64'(so1), 64'h1);

        $display("[TB] basic advance");
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
        checkOutput("adv_ch0", 64'(so0[15:0]),  64'h0002);
        checkOutput("adv_ch1", 64'(so0[31:16]), 64'h0004);

        $display("[TB] loads and feedback");
        applyStimulus(1'b0, 1'b1, 2'd2, 16'h8000);
        checkOutput("load_ch2",     64'(so0[47:32]), 64'h8000);
        checkOutput("load_ready_lo", 64'(lr0), 64'h0);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
        checkOutput("fb_8000",   64'(so0[47:32]), 64'h0001);
        checkOutput("adv_ch0_b", 64'(so0[15:0]),  64'h0004);
        checkOutput("ready_back", 64'(lr0), 64'h1);
        applyStimulus(1'b0, 1'b1, 2'd2, 16'hB800);
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
        checkOutput("fb_B800", 64'(so0[47:32]), 64'h7000);

        $display("[TB] zero seed substitution and load spacing");
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h0000);
        checkOutput("zseed_ch0",  64'(so0[15:0]), 64'h0001);
        checkOutput("zseed_pulse", 64'(zf0), 64'h1);
        checkOutput("zseed_ready", 64'(lr0), 64'h0);
        checkOutput("zseed_wrap", 64'(wr0), 64'h0);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h1234);
        checkOutput("dropped_ch1", 64'(so0[31:16]), 64'h0010);
        checkOutput("zfix_clear",  64'(zf0), 64'h0);
        checkOutput("ready_again", 64'(lr0), 64'h1);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000);

        $display("[TB] 4-bit wrap flag");
        en1 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 3)  checkOutput("w4_step3", 64'(so1), 64'h9);
            if (c == 7)  checkOutput("w4_step7", 64'(so1), 64'hA);
            if (c == 14) checkOutput("w4_pre",   64'(wr1), 64'h0);
        end
        tick();
        checkOutput("w4_rise",  64'(wr1), 64'h1);
        checkOutput("w4_state", 64'(so1), 64'h1);
        repeat (3) tick();
        checkOutput("w4_sticky", 64'(wr1), 64'h1);
        en1 = 1'b0; lv1 = 1'b1; lc1 = 1'b0; ls1 = 4'h5;
        tick();
        lv1 = 1'b0;
        checkOutput("w4_clear", 64'(wr1), 64'h0);
        checkOutput("w4_load",  64'(so1), 64'h5);

        $display("[TB] STEPS=4");
        en2 = 1'b1;
        tick();
        checkOutput("s4_all", 64'(so2), 64'h0080_0040_0020_0010);
        lv2 = 1'b1; lc2 = 2'd1; ls2 = 16'hABCD;
        tick();
        lv2 = 1'b0; en2 = 1'b0;
        checkOutput("s4_loadwin", 64'(so2), 64'h0800_0400_ABCD_0100);

        $display("[TB] asynchronous reset during load");
        en0 = 1'b1; lv0 = 1'b1; lc0 = 2'd3; ls0 = 16'h5555;
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_state0", 64'(so0), 64'h0008_0004_0002_0001);
        checkOutput("arst_ready0", 64'(lr0), 64'h1);
        checkOutput("arst_zfix0",  64'(zf0), 64'h0);
        checkOutput("arst_wrap0",  64'(wr0), 64'h0);
        checkOutput("arst_state2", 64'(so2), 64'h0008_0004_0002_0001);
        checkOutput("arst_state1", 64'(so1), 64'h1);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
        checkOutput("post_rst_ch0", 64'(so0[15:0]),  64'h0002);
        checkOutput("post_rst_ch3", 64'(so0[63:48]), 64'h0010);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
